// File: rtl/phase_a_loader.sv
// Streams an operand into the phase_a stage, fires it once, then streams the
// phase_a result back out least-significant word first.
module phase_a_loader #(
    parameter int Size  = 3072,
    parameter int W     = 64,
    parameter int BEATS = Size / W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s_valid,
    input  logic [W-1:0]    s_data,
    input  logic            s_last,
    output logic            s_ready,
    output logic [Size-1:0] pa_a,
    output logic            pa_en,
    input  logic            pa_done,
    input  logic [Size-1:0] pa_new_a,
    output logic            m_valid,
    output logic [W-1:0]    m_data,
    output logic            m_last,
    input  logic            m_ready,
    output logic            busy,
    output logic            err
);

    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    typedef enum logic [1:0] {LOAD, FIRE, WAIT, UNLOAD} state_t;

    state_t state, state_next;

    logic [CW-1:0]             cnt, cnt_next;
    logic [BEATS-1:0][W-1:0]   words;
    logic [BEATS-1:0][W-1:0]   res;
    logic                      err_next;
    logic                      word_we;
    logic                      res_we;

    assign pa_a   = words;
    assign m_data = res[cnt];
    assign busy   = (state != LOAD);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    // cnt is shared by LOAD and UNLOAD; every state exit leaves it at zero.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        err_next   = 1'b0;
        word_we    = 1'b0;
        res_we     = 1'b0;
        s_ready    = 1'b0;
        pa_en      = 1'b0;
        m_valid    = 1'b0;
        m_last     = 1'b0;
        case (state)
            LOAD: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    word_we = 1'b1;
                    if (cnt == LAST) begin
                        cnt_next = '0;
                        if (s_last) begin
                            state_next = FIRE;
                        end else begin
                            err_next = 1'b1;
                        end
                    end else if (s_last) begin
                        cnt_next = '0;
                        err_next = 1'b1;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
            end
            FIRE: begin
                pa_en      = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (pa_done) begin
                    res_we     = 1'b1;
                    state_next = UNLOAD;
                end
            end
            UNLOAD: begin
                m_valid = 1'b1;
                m_last  = (cnt == LAST);
                if (m_ready) begin
                    if (cnt == LAST) begin
                        cnt_next   = '0;
                        state_next = LOAD;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    // Operand words are only written in LOAD, so pa_a holds through FIRE/WAIT.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt   <= '0;
            err   <= 1'b0;
            words <= '0;
            res   <= '0;
        end else begin
            cnt <= cnt_next;
            err <= err_next;
            if (word_we) begin
                words[cnt] <= s_data;
            end
            if (res_we) begin
                res <= pa_new_a;
            end
        end
    end

endmodule

// File: tb/tb_phase_a_loader.sv
// Scoreboard bench for phase_a_loader with a behavioural phase_a stage that
// returns the bitwise inverse of its operand 20 cycles after each start pulse.
module tb_phase_a_loader;

    localparam int SIZE  = 3072;
    localparam int W     = 64;
    localparam int BEATS = 48;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            s_valid = 1'b0;
    logic [W-1:0]    s_data = '0;
    logic            s_last = 1'b0;
    logic            s_ready;
    logic [SIZE-1:0] pa_a;
    logic            pa_en;
    logic            pa_done;
    logic [SIZE-1:0] pa_new_a;
    logic            m_valid;
    logic [W-1:0]    m_data;
    logic            m_last;
    logic            m_ready;
    logic            busy;
    logic            err;

    logic            model_on = 1'b1;
    logic            model_done = 1'b0;
    logic [SIZE-1:0] model_new_a = '0;
    logic            manual_done = 1'b0;
    logic [SIZE-1:0] manual_val = '0;
    logic            bp_mode = 1'b0;

    int   n_checks = 0;
    int   n_fail = 0;
    int   pa_en_count = 0;
    int   exp_pa_en = 0;
    exp_t sb[$];

    assign pa_done  = model_done | manual_done;
    assign pa_new_a = manual_done ? manual_val : model_new_a;

    phase_a_loader #(.Size(SIZE), .W(W), .BEATS(BEATS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .pa_a     (pa_a),
        .pa_en    (pa_en),
        .pa_done  (pa_done),
        .pa_new_a (pa_new_a),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_last   (m_last),
        .m_ready  (m_ready),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Downstream readiness: always ready, or the 1,0,0,1 back-pressure pattern.
    initial begin
        logic bp_pat [4];
        int   bp_idx;
        bp_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        bp_idx = 0;
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                m_ready = bp_pat[bp_idx];
                bp_idx  = (bp_idx + 1) % 4;
            end else begin
                m_ready = 1'b1;
                bp_idx  = 0;
            end
        end
    end

    // Behavioural phase_a stage.
    initial begin
        logic [SIZE-1:0] cap;
        forever begin
            @(negedge clk);
            if (pa_en && model_on) begin
                cap = pa_a;
                repeat (20) @(posedge clk);
                #1;
                model_done  = 1'b1;
                model_new_a = ~cap;
                @(posedge clk);
                #1;
                model_done  = 1'b0;
                model_new_a = '0;
                @(negedge clk);
                checkOutput("first m_valid latency", 64'(m_valid), 64'd1);
            end
        end
    end

    // Output monitor: pops the scoreboard on every accepted output word.
    initial begin
        exp_t         e;
        logic         held;
        logic [W-1:0] held_data;
        held = 1'b0;
        held_data = '0;
        forever begin
            @(negedge clk);
            if (pa_en) pa_en_count++;
            if (held && m_valid) checkOutput("m_data stable", m_data, held_data);
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected word: got %h expected none", m_data);
                end else begin
                    e = sb.pop_front();
                    checkOutput("m_data", m_data, e.data);
                    checkOutput("m_last", 64'(m_last), 64'(e.last));
                end
            end
            held = m_valid && !m_ready;
            held_data = m_data;
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drives nbeats words k+1; s_last on beat last_at; spurious pa_done on beat spur_at.
    task automatic applyStimulus(input int nbeats, input int last_at, input int spur_at, input bit push);
        int t;
        for (int k = 0; k < nbeats; k++) begin
            s_valid     = 1'b1;
            s_data      = 64'(k + 1);
            s_last      = (k == last_at);
            manual_done = (k == spur_at);
            manual_val  = '1;
            t = 0;
            while (!s_ready && t < 200) begin
                @(posedge clk);
                #1;
                t++;
            end
            if (t >= 200) checkOutput("s_ready timeout", 64'(s_ready), 64'd1);
            @(posedge clk);
            #1;
            if (push) sb.push_back('{data: ~(64'(k + 1)), last: (k == BEATS - 1)});
        end
        s_valid     = 1'b0;
        s_last      = 1'b0;
        manual_done = 1'b0;
    endtask

    task automatic checkOperand();
        logic [SIZE-1:0] exp_a;
        int bad;
        bad = -1;
        for (int k = 0; k < BEATS; k++) exp_a[k*W +: W] = 64'(k + 1);
        for (int k = 0; k < BEATS; k++) begin
            if (pa_a[k*W +: W] !== exp_a[k*W +: W] && bad < 0) bad = k;
        end
        n_checks++;
        if (bad >= 0) begin
            n_fail++;
            $display("[TB] FAIL pa_a word %0d: got %h expected %h", bad, pa_a[bad*W +: W], exp_a[bad*W +: W]);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        checkOutput("scoreboard drained", 64'(sb.size()), 64'd0);
        t = 0;
        while (busy && t < 20) begin
            @(negedge clk);
            t++;
        end
        checkOutput("back to LOAD", 64'(busy), 64'd0);
        checkOutput("s_ready after unload", 64'(s_ready), 64'd1);
        checkOutput("pa_en pulse count", 64'(pa_en_count), 64'(exp_pa_en));
    endtask

    task automatic runFrame(input int spur_at);
        exp_pa_en++;
        applyStimulus(BEATS, BEATS - 1, spur_at, 1'b1);
        @(negedge clk);
        checkOutput("pa_en after last beat", 64'(pa_en), 64'd1);
        checkOperand();
        @(negedge clk);
        checkOutput("pa_en single pulse", 64'(pa_en), 64'd0);
        checkOutput("s_ready held low", 64'(s_ready), 64'd0);
        drain();
        @(posedge clk);
        #1;
    endtask

    initial begin
        $display("[TB] start");
        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset s_ready", 64'(s_ready), 64'd1);
        checkOutput("reset pa_en", 64'(pa_en), 64'd0);
        checkOutput("reset m_valid", 64'(m_valid), 64'd0);
        checkOutput("reset m_last", 64'(m_last), 64'd0);
        checkOutput("reset err", 64'(err), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset m_data", m_data, 64'd0);
        checkOutput("reset pa_a", 64'(pa_a != '0), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("s_ready after release", 64'(s_ready), 64'd1);
        @(posedge clk);
        #1;

        $display("[TB] nominal frame");
        runFrame(-1);

        $display("[TB] back-pressure frame");
        bp_mode = 1'b1;
        runFrame(-1);
        bp_mode = 1'b0;

        $display("[TB] early s_last");
        applyStimulus(11, 10, -1, 1'b0);
        @(negedge clk);
        checkOutput("early err pulse", 64'(err), 64'd1);
        checkOutput("early cnt cleared", 64'(dut.cnt), 64'd0);
        checkOutput("early stays LOAD", 64'(busy), 64'd0);
        checkOutput("early no pa_en", 64'(pa_en), 64'd0);
        @(negedge clk);
        checkOutput("early err one cycle", 64'(err), 64'd0);
        @(posedge clk);
        #1;
        runFrame(-1);

        $display("[TB] missing s_last");
        applyStimulus(BEATS, -1, -1, 1'b0);
        @(negedge clk);
        checkOutput("missing err pulse", 64'(err), 64'd1);
        checkOutput("missing stays LOAD", 64'(busy), 64'd0);
        checkOutput("missing cnt cleared", 64'(dut.cnt), 64'd0);
        @(negedge clk);
        checkOutput("missing err one cycle", 64'(err), 64'd0);
        repeat (5) @(negedge clk);
        checkOutput("missing no pa_en", 64'(pa_en_count), 64'(exp_pa_en));
        checkOutput("missing s_ready", 64'(s_ready), 64'd1);
        @(posedge clk);
        #1;
        runFrame(-1);

        $display("[TB] spurious pa_done in LOAD");
        runFrame(5);

        $display("[TB] reset in WAIT");
        model_on = 1'b0;
        exp_pa_en++;
        applyStimulus(BEATS, BEATS - 1, -1, 1'b0);
        @(negedge clk);
        checkOutput("wait-test pa_en", 64'(pa_en), 64'd1);
        repeat (5) @(negedge clk);
        checkOutput("in WAIT busy", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort busy", 64'(busy), 64'd0);
        checkOutput("abort s_ready", 64'(s_ready), 64'd1);
        checkOutput("abort pa_a cleared", 64'(pa_a != '0), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        manual_done = 1'b1;
        manual_val  = '1;
        @(posedge clk);
        #1;
        manual_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("late pa_done m_valid", 64'(m_valid), 64'd0);
            checkOutput("late pa_done busy", 64'(busy), 64'd0);
        end
        checkOutput("late pa_done res", 64'(dut.res != '0), 64'd0);
        model_on = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] recovery frame");
        runFrame(-1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
